// File: rtl/mux_sel_sequencer.sv
// Select-code sequencer for the 5:1 select mux tree. The select code advances on a
// debounced button press (manual mode) or at a fixed period (auto mode).
module mux_sel_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned AUTO_PERIOD     = 50000000,
    parameter int unsigned NUM_SEL         = 5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Step,
    input  logic       Auto,
    input  logic       Clear,
    output logic [2:0] S,
    output logic       Mode,
    output logic       Wrap
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD - 1);
    localparam logic [2:0]    SEL_LAST = 3'(NUM_SEL - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    mode_t          state;
    mode_t          next_state;
    logic [2:0]     sync1;
    logic [2:0]     sync2;
    logic           step_s;
    logic           auto_s;
    logic           clr_s;
    logic           stable;
    logic [DW-1:0]  deb_cnt;
    logic [PW-1:0]  per_cnt;
    logic           deb_hit;
    logic           adv_btn;
    logic           adv_tmr;
    logic           adv;

    // Two-flop synchronizers, bit order {Step, Auto, Clear}
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {Step, Auto, Clear};
            sync2 <= sync1;
        end
    end

    always_comb begin
        step_s = sync2[2];
        auto_s = sync2[1];
        clr_s  = sync2[0];
    end

    // Only a rising flip of the debounced value requests an advance
    always_comb begin
        deb_hit = (step_s != stable) && (deb_cnt == DEB_LAST);
        adv_btn = deb_hit && step_s;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stable  <= 1'b0;
            deb_cnt <= '0;
        end else if (deb_hit) begin
            stable  <= step_s;
            deb_cnt <= '0;
        end else if (step_s != stable) begin
            deb_cnt <= deb_cnt + 1'b1;
        end else begin
            deb_cnt <= '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= MANUAL;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            MANUAL:  if (auto_s)  next_state = AUTO;
            AUTO:    if (!auto_s) next_state = MANUAL;
            default: next_state = MANUAL;
        endcase
        Mode = (state == AUTO);
    end

    always_comb begin
        adv_tmr = (state == AUTO) && (per_cnt == PER_LAST);
        adv     = adv_btn || adv_tmr;
    end

    // Any advance restarts the period, so a button press and a timer tick
    // landing on the same edge collapse into one advance
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            per_cnt <= '0;
        end else if (clr_s || (state != AUTO) || adv) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            S    <= '0;
            Wrap <= 1'b0;
        end else if (clr_s) begin
            S    <= '0;
            Wrap <= 1'b0;
        end else if (adv) begin
            S    <= (S == SEL_LAST) ? 3'd0 : S + 3'd1;
            Wrap <= (S == SEL_LAST);
        end else begin
            Wrap <= 1'b0;
        end
    end

endmodule
